// File: rtl/mvm_seq_ctrl.sv
// Sequencing controller for the single-MAC matrix-vector datapath.
// Drives memory addresses, write enables and clear_acc with valid/ready
// handshaking on load and drain; never touches data.
module mvm_seq_ctrl #(
   parameter int unsigned K    = 32,
   parameter int unsigned LOGK = $clog2(K)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                loadMatrix,
   input  logic                loadVector,
   input  logic                in_valid,
   input  logic                out_ready,
   output logic [2*LOGK-1:0]   addr_a,
   output logic                wr_en_a,
   output logic [LOGK-1:0]     addr_x,
   output logic                wr_en_x,
   output logic [LOGK-1:0]     addr_y,
   output logic                wr_en_y,
   output logic                clear_acc,
   output logic                out_valid,
   output logic                busy,
   output logic                done
);

   localparam int unsigned AW = 2 * LOGK;
   localparam logic [LOGK-1:0] LAST = LOGK'(K - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_X,
      S_MAC,
      S_DRAIN,
      S_WRITE_Y,
      S_OUT_RD,
      S_OUT_VALID
   } state_t;

   state_t          state, state_nxt;
   logic [LOGK-1:0] row, row_nxt;
   logic [LOGK-1:0] col, col_nxt;
   logic            drn, drn_nxt;
   logic            done_nxt;
   logic [AW-1:0]   rc_inc;

   // Linear {row,col} increment used while streaming matrix A in
   assign rc_inc = AW'({row, col} + AW'(1));

   // State, counters and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         row       <= '0;
         col       <= '0;
         drn       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         row       <= row_nxt;
         col       <= col_nxt;
         drn       <= drn_nxt;
         out_valid <= (state_nxt == S_OUT_VALID);
         busy      <= (state_nxt != S_IDLE);
         done      <= done_nxt;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      drn_nxt   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_MAC;
               row_nxt   = '0;
               col_nxt   = '0;
            end else if (loadMatrix) begin
               state_nxt = S_LOAD_A;
               row_nxt   = '0;
               col_nxt   = '0;
            end else if (loadVector) begin
               state_nxt = S_LOAD_X;
               row_nxt   = '0;
               col_nxt   = '0;
            end
         end
         S_LOAD_A: begin
            if (in_valid) begin
               if (row == LAST && col == LAST) begin
                  state_nxt = S_IDLE;
                  row_nxt   = '0;
                  col_nxt   = '0;
               end else begin
                  {row_nxt, col_nxt} = rc_inc;
               end
            end
         end
         S_LOAD_X: begin
            if (in_valid) begin
               if (col == LAST) begin
                  state_nxt = S_IDLE;
                  col_nxt   = '0;
               end else begin
                  col_nxt = LOGK'(col + LOGK'(1));
               end
            end
         end
         S_MAC: begin
            if (col == LAST) begin
               state_nxt = S_DRAIN;
               col_nxt   = '0;
            end else begin
               col_nxt = LOGK'(col + LOGK'(1));
            end
         end
         S_DRAIN: begin
            // Two cycles cover memory read plus product-register latency
            if (drn) state_nxt = S_WRITE_Y;
            else     drn_nxt   = 1'b1;
         end
         S_WRITE_Y: begin
            if (row == LAST) begin
               state_nxt = S_OUT_RD;
               row_nxt   = '0;
            end else begin
               state_nxt = S_MAC;
               row_nxt   = LOGK'(row + LOGK'(1));
            end
         end
         S_OUT_RD: begin
            state_nxt = S_OUT_VALID;
         end
         S_OUT_VALID: begin
            if (out_ready) begin
               if (row == LAST) begin
                  state_nxt = S_IDLE;
                  row_nxt   = '0;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_OUT_RD;
                  row_nxt   = LOGK'(row + LOGK'(1));
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
         end
      endcase
   end

   // Memory-control decodes of the registered state and counters
   assign wr_en_a   = (state == S_LOAD_A) && in_valid;
   assign wr_en_x   = (state == S_LOAD_X) && in_valid;
   assign wr_en_y   = (state == S_WRITE_Y);
   assign clear_acc = (state == S_MAC) && (col == '0);
   assign addr_a    = {row, col};
   assign addr_x    = col;
   assign addr_y    = row;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl: a behavioural datapath (memories + two-stage MAC)
// is driven by the controller, and drained Y words are compared against a
// matrix-vector product computed directly from the loaded data.
module tb_mvm_seq_ctrl;

   localparam int K    = 32;
   localparam int LOGK = 5;

   logic              clk = 1'b0;
   logic              reset, start, loadMatrix, loadVector, in_valid, out_ready;
   logic [2*LOGK-1:0] addr_a;
   logic [LOGK-1:0]   addr_x, addr_y;
   logic              wr_en_a, wr_en_x, wr_en_y, clear_acc, out_valid, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] data_in;
   logic [15:0] a_ref [K*K];
   logic [15:0] x_ref [K];
   logic [63:0] y_ref [K];

   logic [15:0] mem_a [K*K];
   logic [15:0] mem_x [K];
   logic [63:0] mem_y [K];
   logic [15:0] rd_a, rd_x;
   logic [63:0] prod, acc, dout;

   mvm_seq_ctrl #(.K(K), .LOGK(LOGK)) dut (
      .clk(clk), .reset(reset), .start(start), .loadMatrix(loadMatrix),
      .loadVector(loadVector), .in_valid(in_valid), .out_ready(out_ready),
      .addr_a(addr_a), .wr_en_a(wr_en_a), .addr_x(addr_x), .wr_en_x(wr_en_x),
      .addr_y(addr_y), .wr_en_y(wr_en_y), .clear_acc(clear_acc),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: 1-cycle memory reads, product register, accumulator
   always @(posedge clk) begin
      if (wr_en_a) mem_a[addr_a] <= data_in;
      if (wr_en_x) mem_x[addr_x] <= data_in;
      if (wr_en_y) mem_y[addr_y] <= acc;
      rd_a <= mem_a[addr_a];
      rd_x <= mem_x[addr_x];
      dout <= mem_y[addr_y];
      prod <= clear_acc ? 64'd0 : 64'(rd_a) * 64'(rd_x);
      acc  <= clear_acc ? 64'd0 : acc + prod;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_addr_a"}, 64'(addr_a), 0);
      chk({tag, "_addr_x"}, 64'(addr_x), 0);
      chk({tag, "_addr_y"}, 64'(addr_y), 0);
      chk({tag, "_wr_en"}, {61'd0, wr_en_a, wr_en_x, wr_en_y}, 0);
      chk({tag, "_clear_acc"}, 64'(clear_acc), 0);
      chk({tag, "_out_valid"}, 64'(out_valid), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_done"}, 64'(done), 0);
   endtask

   function automatic void calc_y();
      for (int r = 0; r < K; r++) begin
         logic [63:0] s;
         s = 64'd0;
         for (int c = 0; c < K; c++) s += 64'(a_ref[r*K+c]) * 64'(x_ref[c]);
         y_ref[r] = s;
      end
   endfunction

   // gmode: 0 always valid, 1 pattern 1,0,0, 2 random gaps
   task automatic load_a(input int gmode, input bit both);
      int idx, n;
      bit v;
      loadMatrix = 1'b1; loadVector = both;
      tick();
      loadMatrix = 1'b0; loadVector = 1'b0;
      idx = 0; n = 0;
      while (idx < K*K && n < 8000) begin
         v = (gmode == 0) ? 1'b1 : (gmode == 1) ? (n % 3 == 0) : 1'($urandom % 2);
         in_valid = v;
         data_in  = a_ref[idx < K*K ? idx : 0];
         #1;
         chk("load_a_wr_en_a", 64'(wr_en_a), 64'(v));
         chk("load_a_wr_en_x", 64'(wr_en_x), 0);
         if (v) chk("load_a_addr", 64'(addr_a), 64'(idx));
         idx += int'(v);
         tick();
         n++;
      end
      in_valid = 1'b0;
      #1;
      chk("load_a_complete", 64'(idx), K*K);
      chk("load_a_idle_busy", 64'(busy), 0);
   endtask

   task automatic load_x(input int gmode);
      int idx, n;
      bit v;
      loadVector = 1'b1;
      tick();
      loadVector = 1'b0;
      idx = 0; n = 0;
      while (idx < K && n < 1000) begin
         v = (gmode == 0) ? 1'b1 : 1'($urandom % 2);
         in_valid = v;
         data_in  = x_ref[idx < K ? idx : 0];
         #1;
         chk("load_x_wr_en_x", 64'(wr_en_x), 64'(v));
         chk("load_x_wr_en_a", 64'(wr_en_a), 0);
         if (v) chk("load_x_addr", 64'(addr_x), 64'(idx));
         idx += int'(v);
         tick();
         n++;
      end
      in_valid = 1'b0;
      #1;
      chk("load_x_complete", 64'(idx), K);
      chk("load_x_idle_busy", 64'(busy), 0);
   endtask

   // rmode: 0 ready tied 1, 1 random ready, 2 ready low 5 cycles at word 7
   task automatic run_compute(input int rmode, input bit inject, input bit with_lm, input int abort_row);
      int s, nwy, last_wy, word, ndone, n, hold;
      bit rdy, seen_ov, phase;
      nwy = 0; last_wy = 0; word = 0; ndone = 0; n = 0; hold = 0;
      seen_ov = 1'b0; phase = 1'b0;
      calc_y();
      start = 1'b1; loadMatrix = with_lm;
      s = cyc;
      tick();
      start = 1'b0; loadMatrix = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("mac_entry_clear", 64'(clear_acc), 1);
      chk("mac_entry_wr_en_a", 64'(wr_en_a), 0);
      chk("mac_entry_busy", 64'(busy), 1);
      while (ndone == 0 && n < 3000) begin
         if (inject && busy) begin
            start      = 1'($urandom % 4 == 0);
            loadMatrix = 1'($urandom % 4 == 0);
            loadVector = 1'($urandom % 4 == 0);
            in_valid   = 1'($urandom % 2);
         end else begin
            start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; in_valid = 1'b0;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom % 3 != 0);
            default: rdy = !(word == 7 && hold < 5);
         endcase
         out_ready = rdy;
         #1;
         chk("cmp_no_wr_en_a", 64'(wr_en_a), 0);
         chk("cmp_no_wr_en_x", 64'(wr_en_x), 0);
         if (wr_en_y) begin
            if (nwy == 0) chk("first_wr_en_y", 64'(cyc - s), K + 3);
            else          chk("wr_en_y_spacing", 64'(cyc - last_wy), K + 3);
            chk("wr_en_y_addr", 64'(addr_y), 64'(nwy));
            last_wy = cyc;
            nwy++;
         end
         if (abort_row >= 0 && nwy == abort_row && cyc == last_wy + 3) begin
            chk("abort_mac_addr", 64'(addr_a), 64'(abort_row * K + 2));
            start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; in_valid = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            #1;
            chk_idle("abort");
            return;
         end
         if (rmode == 0 && seen_ov) begin
            phase = ~phase;
            chk("out_valid_alternate", 64'(out_valid), 64'(phase));
         end
         if (out_valid) begin
            if (!seen_ov) begin
               chk("first_out_valid", 64'(cyc - s), K * (K + 3) + 2);
               seen_ov = 1'b1;
               phase   = 1'b1;
            end
            chk("y_data", dout, y_ref[word < K ? word : 0]);
            chk("y_addr", 64'(addr_y), 64'(word));
            if (rdy) word++;
            else     hold++;
         end
         if (done) begin
            ndone++;
            chk("done_words", 64'(word), K);
            chk("done_busy", 64'(busy), 0);
         end else begin
            chk("busy_high", 64'(busy), 1);
         end
         if (ndone == 0) tick();
         n++;
      end
      chk("done_seen", 64'(ndone), 1);
      chk("wr_en_y_count", 64'(nwy), K);
      if (rmode == 2) chk("backpressure_cycles", 64'(hold), 5);
      tick();
      start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("done_single_pulse", 64'(done), 0);
      chk("idle_after_done", 64'(busy), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      reset = 1'b0;
      tick();
      chk_idle("post_reset");

      // Identity matrix, X = 1..K
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) a_ref[r*K+c] = (r == c) ? 16'd1 : 16'd0;
      for (int c = 0; c < K; c++) x_ref[c] = 16'(c + 1);
      load_a(1, 1'b0);
      load_x(0);
      run_compute(0, 1'b0, 1'b0, -1);

      // A all 2, X all 3: every row sums to 192
      for (int i = 0; i < K*K; i++) a_ref[i] = 16'd2;
      for (int c = 0; c < K; c++) x_ref[c] = 16'd3;
      load_a(0, 1'b0);
      load_x(2);
      run_compute(0, 1'b0, 1'b0, -1);

      // Random data, random gaps, loadMatrix beats loadVector, start beats loadMatrix
      for (int i = 0; i < K*K; i++) a_ref[i] = 16'($urandom);
      for (int c = 0; c < K; c++) x_ref[c] = 16'($urandom);
      load_a(2, 1'b1);
      load_x(2);
      run_compute(1, 1'b1, 1'b1, -1);

      // Consumer stalls on word 7
      run_compute(2, 1'b0, 1'b0, -1);

      // Reset in the middle of row 5, then a full fresh pass
      run_compute(0, 1'b1, 1'b0, 5);
      tick();
      run_compute(1, 1'b0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
